// File: rtl/l1_trace_issuer_if.sv
// Bundles the trace-record input, the L1/snoop request ports and the status outputs of
// l1_trace_issuer. The bench drives through master; the issuer connects through slave.
interface l1_trace_issuer_if #(
  parameter int commandSize = 8,
  parameter int addressSize = 32
);
  logic                   traceValid;
  logic                   traceReady;
  logic [commandSize-1:0] traceCommand;
  logic [addressSize-1:0] traceAddress;

  logic                   l1Valid;
  logic [commandSize-1:0] l1Command;
  logic [addressSize-1:0] l1Address;
  logic                   l1Done;

  logic                   snoopValid;
  logic [commandSize-1:0] snoopCommand;
  logic [addressSize-1:0] snoopAddress;
  logic                   snoopDone;

  logic                   clearPulse;
  logic                   printPulse;
  logic [15:0]            badCommandCount;
  logic                   timeoutError;
  logic                   idle;

  modport master (
    output traceValid, traceCommand, traceAddress, l1Done, snoopDone,
    input  traceReady, l1Valid, l1Command, l1Address,
           snoopValid, snoopCommand, snoopAddress,
           clearPulse, printPulse, badCommandCount, timeoutError, idle
  );

  modport slave (
    input  traceValid, traceCommand, traceAddress, l1Done, snoopDone,
    output traceReady, l1Valid, l1Command, l1Address,
           snoopValid, snoopCommand, snoopAddress,
           clearPulse, printPulse, badCommandCount, timeoutError, idle
  );
endinterface

// File: rtl/l1_trace_issuer.sv
// Buffers decoded trace records in a small FIFO and issues them in order, one outstanding
// request at a time, to the L1 or snoop port of the cache model, with a completion watchdog.
module l1_trace_issuer #(
  parameter int commandSize   = 8,
  parameter int addressSize   = 32,
  parameter int fifoDepth     = 4,
  parameter int timeoutCycles = 255
) (
  input logic              clock,
  input logic              reset,
  l1_trace_issuer_if.slave bus
);

  localparam int AW = $clog2(fifoDepth);
  localparam int PW = AW + 1;
  localparam int TW = (timeoutCycles > 1) ? $clog2(timeoutCycles) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_L1,
    ST_WAIT_SNOOP
  } state_e;

  typedef enum logic [2:0] {
    DEC_L1,
    DEC_SNOOP,
    DEC_CLEAR,
    DEC_PRINT,
    DEC_BAD
  } decode_e;

  typedef struct packed {
    logic [commandSize-1:0] cmd;
    logic [addressSize-1:0] addr;
  } record_t;

  function automatic decode_e decode(input logic [commandSize-1:0] cmd);
    if (cmd <= commandSize'(2))      return DEC_L1;
    else if (cmd <= commandSize'(6)) return DEC_SNOOP;
    else if (cmd == commandSize'(8)) return DEC_CLEAR;
    else if (cmd == commandSize'(9)) return DEC_PRINT;
    else                             return DEC_BAD;
  endfunction

  // Record FIFO: pointers carry one extra wrap bit to tell full from empty.
  record_t          mem_q [fifoDepth];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             fifo_empty, fifo_full;
  logic             push, pop;
  record_t          head;

  assign fifo_empty     = (wr_ptr_q == rd_ptr_q);
  assign fifo_full      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                          (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign bus.traceReady = !fifo_full && !reset;
  assign push           = bus.traceValid && bus.traceReady;
  assign head           = mem_q[rd_ptr_q[AW-1:0]];
  assign wr_ptr_d       = wr_ptr_q + PW'(push);
  assign rd_ptr_d       = rd_ptr_q + PW'(pop);

  // NOTE: the storage array has no reset; the pointers alone decide which entries are live,
  // so flushing on reset costs nothing and the array can map onto plain RAM/flops.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= '{cmd: bus.traceCommand, addr: bus.traceAddress};
  end

  // Issue FSM and its registered outputs.
  state_e                 state_q, state_d;
  logic [commandSize-1:0] l1_cmd_q, l1_cmd_d;
  logic [addressSize-1:0] l1_addr_q, l1_addr_d;
  logic [commandSize-1:0] sn_cmd_q, sn_cmd_d;
  logic [addressSize-1:0] sn_addr_q, sn_addr_d;
  logic                   clear_q, clear_d;
  logic                   print_q, print_d;
  logic [15:0]            bad_q, bad_d;
  logic                   timeout_q, timeout_d;
  logic                   idle_q, idle_d;
  logic [TW-1:0]          wd_q, wd_d;
  logic                   wd_expired;

  assign wd_expired = (wd_q == TW'(timeoutCycles - 1));

  // NOTE: every signal written here gets a default first, so no path through the case
  // statements can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    l1_cmd_d  = l1_cmd_q;
    l1_addr_d = l1_addr_q;
    sn_cmd_d  = sn_cmd_q;
    sn_addr_d = sn_addr_q;
    clear_d   = 1'b0;
    print_d   = 1'b0;
    bad_d     = bad_q;
    timeout_d = timeout_q;
    wd_d      = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          unique case (decode(head.cmd))
            DEC_L1: begin
              l1_cmd_d  = head.cmd;
              l1_addr_d = head.addr;
              state_d   = ST_WAIT_L1;
            end
            DEC_SNOOP: begin
              sn_cmd_d  = head.cmd;
              sn_addr_d = head.addr;
              state_d   = ST_WAIT_SNOOP;
            end
            DEC_CLEAR: clear_d = 1'b1;
            DEC_PRINT: print_d = 1'b1;
            default:   if (bad_q != 16'hFFFF) bad_d = bad_q + 16'd1;
          endcase
        end
      end

      // A done in the expiry cycle takes priority, so the request completes cleanly.
      ST_WAIT_L1: begin
        if (bus.l1Done) begin
          state_d = ST_IDLE;
        end else if (wd_expired) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          wd_d = wd_q + TW'(1);
        end
      end

      ST_WAIT_SNOOP: begin
        if (bus.snoopDone) begin
          state_d = ST_IDLE;
        end else if (wd_expired) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          wd_d = wd_q + TW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    idle_d = (state_d == ST_IDLE) && (wr_ptr_d == rd_ptr_d);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the values
  // from before the edge, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      l1_cmd_q  <= '0;
      l1_addr_q <= '0;
      sn_cmd_q  <= '0;
      sn_addr_q <= '0;
      clear_q   <= 1'b0;
      print_q   <= 1'b0;
      bad_q     <= '0;
      timeout_q <= 1'b0;
      idle_q    <= 1'b1;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      l1_cmd_q  <= l1_cmd_d;
      l1_addr_q <= l1_addr_d;
      sn_cmd_q  <= sn_cmd_d;
      sn_addr_q <= sn_addr_d;
      clear_q   <= clear_d;
      print_q   <= print_d;
      bad_q     <= bad_d;
      timeout_q <= timeout_d;
      idle_q    <= idle_d;
      wd_q      <= wd_d;
    end
  end

  assign bus.l1Valid         = (state_q == ST_WAIT_L1);
  assign bus.l1Command       = l1_cmd_q;
  assign bus.l1Address       = l1_addr_q;
  assign bus.snoopValid      = (state_q == ST_WAIT_SNOOP);
  assign bus.snoopCommand    = sn_cmd_q;
  assign bus.snoopAddress    = sn_addr_q;
  assign bus.clearPulse      = clear_q;
  assign bus.printPulse      = print_q;
  assign bus.badCommandCount = bad_q;
  assign bus.timeoutError    = timeout_q;
  assign bus.idle            = idle_q;

  // Requests and pulses are mutually exclusive by construction.
  assert property (@(posedge clock) disable iff (reset)
    $onehot0({bus.l1Valid, bus.snoopValid, bus.clearPulse, bus.printPulse}));

endmodule

// File: tb/tb_l1_trace_issuer.sv
// Scoreboard bench for l1_trace_issuer: accepted records are classified into an expected
// issue queue; a monitor pops and compares whenever a request or pulse appears.
module tb_l1_trace_issuer;

  localparam int CW    = 8;
  localparam int ADW   = 32;
  localparam int DEPTH = 4;
  localparam int TO    = 255;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  l1_trace_issuer_if #(.commandSize(CW), .addressSize(ADW)) bus ();

  l1_trace_issuer #(
    .commandSize  (CW),
    .addressSize  (ADW),
    .fifoDepth    (DEPTH),
    .timeoutCycles(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef enum int {K_L1, K_SNOOP, K_CLEAR, K_PRINT} kind_e;
  typedef struct {
    kind_e           kind;
    logic [CW-1:0]   cmd;
    logic [ADW-1:0]  addr;
  } issue_t;

  issue_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int model_bad = 0;
  int issued = 0;
  int cyc = 0;
  int last_clear_cyc = -10;
  int last_print_cyc = -10;
  bit resp_random = 1'b0;
  bit force_l1 = 1'b0;
  bit force_snoop = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: classifies an accepted record by its command code.
  function automatic void model_accept(input logic [CW-1:0] cmd, input logic [ADW-1:0] addr);
    issue_t e;
    e.cmd  = cmd;
    e.addr = addr;
    if (cmd <= 2) begin
      e.kind = K_L1;
      exp_q.push_back(e);
    end else if (cmd <= 6) begin
      e.kind = K_SNOOP;
      exp_q.push_back(e);
    end else if (cmd == 8) begin
      e.kind = K_CLEAR;
      exp_q.push_back(e);
    end else if (cmd == 9) begin
      e.kind = K_PRINT;
      exp_q.push_back(e);
    end else if (model_bad < 65535) begin
      model_bad++;
    end
  endfunction

  // Cache responder: the only driver of the done inputs.
  always @(negedge clock) begin
    bus.l1Done    = force_l1    || (resp_random && ($urandom_range(0, 3) == 0));
    bus.snoopDone = force_snoop || (resp_random && ($urandom_range(0, 3) == 0));
  end

  task automatic observe(input kind_e k, input logic [CW-1:0] c, input logic [ADW-1:0] a);
    issued++;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_issue: got kind %0d cmd %0d addr 0x%0h, expected nothing", k, c, a);
    end else begin
      issue_t e;
      e = exp_q.pop_front();
      check("issue_kind", k, e.kind);
      if (k == K_L1 || k == K_SNOOP) begin
        check("issue_cmd", c, e.cmd);
        check("issue_addr", a, e.addr);
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  logic           prev_l1 = 1'b0;
  logic           prev_sn = 1'b0;
  logic [CW-1:0]  held_cmd;
  logic [ADW-1:0] held_addr;

  always @(negedge clock) begin
    if (reset !== 1'b0) begin
      prev_l1 = 1'b0;
      prev_sn = 1'b0;
    end else begin
      check("one_hot_outputs",
            $onehot0({bus.l1Valid, bus.snoopValid, bus.clearPulse, bus.printPulse}), 1);
      if (bus.l1Valid && !prev_l1) begin
        observe(K_L1, bus.l1Command, bus.l1Address);
        held_cmd  = bus.l1Command;
        held_addr = bus.l1Address;
      end else if (bus.l1Valid) begin
        check("l1_stable", {bus.l1Command, bus.l1Address}, {held_cmd, held_addr});
      end
      if (bus.snoopValid && !prev_sn) begin
        observe(K_SNOOP, bus.snoopCommand, bus.snoopAddress);
        held_cmd  = bus.snoopCommand;
        held_addr = bus.snoopAddress;
      end else if (bus.snoopValid) begin
        check("snoop_stable", {bus.snoopCommand, bus.snoopAddress}, {held_cmd, held_addr});
      end
      if (bus.clearPulse) begin
        observe(K_CLEAR, '0, '0);
        last_clear_cyc = cyc;
      end
      if (bus.printPulse) begin
        observe(K_PRINT, '0, '0);
        last_print_cyc = cyc;
      end
      prev_l1 = bus.l1Valid;
      prev_sn = bus.snoopValid;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Offers one record until accepted; returns the cycle of acceptance.
  task automatic push(input logic [CW-1:0] cmd, input logic [ADW-1:0] addr, output int acc);
    logic rdy;
    bit   done = 1'b0;
    bus.traceValid   = 1'b1;
    bus.traceCommand = cmd;
    bus.traceAddress = addr;
    acc = -1;
    for (int i = 0; i < 700; i++) begin
      rdy = bus.traceReady;
      step();
      if (rdy) begin
        model_accept(cmd, addr);
        acc  = cyc;
        done = 1'b1;
        break;
      end
    end
    bus.traceValid = 1'b0;
    if (!done) check("push_accept_timeout", 0, 1);
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && bus.idle && !bus.l1Valid && !bus.snoopValid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check("drain_complete", ok, 1);
    check("bad_count", bus.badCommandCount, model_bad);
  endtask

  initial begin
    int acc[5];
    int a0;
    int cnt;
    int issued_before;
    logic [CW-1:0] c;

    reset            = 1'b1;
    bus.traceValid   = 1'b0;
    bus.traceCommand = '0;
    bus.traceAddress = '0;
    step(3);
    check("reset_traceReady", bus.traceReady, 0);
    check("reset_idle", bus.idle, 1);
    check("reset_l1Valid", bus.l1Valid, 0);
    check("reset_snoopValid", bus.snoopValid, 0);
    check("reset_pulses", {bus.clearPulse, bus.printPulse}, 0);
    check("reset_badCount", bus.badCommandCount, 0);
    check("reset_timeoutError", bus.timeoutError, 0);
    reset = 1'b0;
    step();
    check("ready_after_reset", bus.traceReady, 1);

    // Single L1 read: latency and hold behaviour.
    push(8'd0, 32'h0000_1040, a0);
    check("t1_valid_low_n1", bus.l1Valid, 0);
    step();
    check("t1_valid_n2", bus.l1Valid, 1);
    check("t1_cmd", bus.l1Command, 0);
    check("t1_addr", bus.l1Address, 32'h0000_1040);
    step();
    check("t1_valid_held", bus.l1Valid, 1);
    step();
    check("t1_valid_held2", bus.l1Valid, 1);
    force_l1 = 1'b1;
    step();
    force_l1 = 1'b0;
    check("t1_valid_low_after_done", bus.l1Valid, 0);
    drain();

    // Five back-to-back records with a stalled cache fill the FIFO behind one in flight.
    for (int i = 0; i < 5; i++) push(CW'($urandom_range(0, 6)), $urandom, acc[i]);
    check("t2_back_to_back", acc[4] - acc[0], 4);
    check("t2_ready_low_full", bus.traceReady, 0);
    step(3);
    check("t2_ready_stays_low", bus.traceReady, 0);
    resp_random = 1'b1;
    drain();

    // Clear, print, bad code, snoop read.
    issued_before = issued;
    push(8'd8, 32'h0, a0);
    push(8'd9, 32'h0, a0);
    push(8'd7, 32'h0, a0);
    push(8'd4, 32'hABCD_0000, a0);
    drain();
    check("t3_pulses_consecutive", last_print_cyc - last_clear_cyc, 1);
    check("t3_issue_count", issued - issued_before, 3);

    // Watchdog expiry with no done, then normal traffic.
    resp_random = 1'b0;
    push(8'd1, 32'h0000_2000, a0);
    step();
    cnt = 0;
    while (bus.l1Valid && cnt < 400) begin
      cnt++;
      step();
    end
    check("t4_valid_cycles", cnt, TO);
    check("t4_timeoutError", bus.timeoutError, 1);
    resp_random = 1'b1;
    push(8'd2, 32'h0000_3000, a0);
    drain();
    check("t4_timeout_sticky", bus.timeoutError, 1);

    // Reset while waiting on a snoop with three records queued.
    resp_random = 1'b0;
    push(8'd6, 32'h0000_4000, a0);
    for (int i = 0; i < 3; i++) push(CW'($urandom_range(0, 6)), $urandom, a0);
    check("t5_in_wait_snoop", bus.snoopValid, 1);
    reset = 1'b1;
    step();
    check("t5_snoopValid_cleared", bus.snoopValid, 0);
    check("t5_idle", bus.idle, 1);
    check("t5_ready_in_reset", bus.traceReady, 0);
    exp_q.delete();
    model_bad = 0;
    reset = 1'b0;
    issued_before = issued;
    resp_random = 1'b1;
    step(20);
    check("t5_nothing_issued", issued - issued_before, 0);
    check("t5_idle_after", bus.idle, 1);
    check("t5_timeout_cleared", bus.timeoutError, 0);

    // Done on the exact expiry cycle wins over the watchdog.
    resp_random = 1'b0;
    push(8'd0, 32'h0000_5000, a0);
    step();
    cnt = 0;
    while (bus.l1Valid && cnt < 400) begin
      cnt++;
      if (cnt == TO) force_l1 = 1'b1;
      step();
    end
    force_l1 = 1'b0;
    check("t6_valid_cycles", cnt, TO);
    check("t6_no_timeout", bus.timeoutError, 0);

    // Randomised mixed traffic with stray done pulses.
    resp_random = 1'b1;
    for (int i = 0; i < 60; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r <= 9)       c = CW'(r);
      else if (r <= 11) c = CW'($urandom_range(10, 255));
      else              c = CW'($urandom_range(0, 6));
      push(c, $urandom, a0);
      step($urandom_range(0, 2));
    end
    drain();
    check("t7_no_timeout", bus.timeoutError, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
